// File: rtl/data_memory_if.sv
// Request/response bundle between the execute stage and the data memory.
// The memory side uses the slave modport, the requester uses master.
interface data_memory_if;
   logic [63:0] Address;
   logic [63:0] WriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  Funct3;
   logic [63:0] ReadData;
   logic        Ready;
   logic        Busy;
   logic        Fault;

   modport master (
      output Address, WriteData, MemRead, MemWrite, Funct3,
      input  ReadData, Ready, Busy, Fault
   );

   modport slave (
      input  Address, WriteData, MemRead, MemWrite, Funct3,
      output ReadData, Ready, Busy, Fault
   );
endinterface

// File: rtl/data_memory.sv
// Byte-addressed, little-endian doubleword data memory with a fixed
// three-state handshake: a request is captured in IDLE, performed in ACCESS
// and reported in DONE with a single-cycle Ready pulse.
module data_memory #(
   parameter int DEPTH = 256
) (
   input logic         clk,
   input logic         reset,
   data_memory_if.slave bus
);

   localparam int IdxW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;
   typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_BOTH} opT;

   stateT       state_q;
   opT          op_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [2:0]  funct3_q;
   logic [63:0] readData_q;
   logic        ready_q;
   logic        busy_q;
   logic        fault_q;

   logic [63:0] memArray [DEPTH];

   logic [2:0]      lane;
   logic [IdxW-1:0] wordIdx;
   logic [7:0]      sizeMask;
   logic            misaligned;
   logic            outOfRange;
   logic            badFunct;
   logic            accessFault_d;
   logic [63:0]     loadWord;
   logic [63:0]     loadData;
   logic [63:0]     readData_d;
   logic [7:0]      byteEn;
   logic [63:0]     storeData;
   logic            storeEn;

   // Decode the captured request: lane/size, fault conditions, load
   // extraction and the byte-lane-aligned store data.
   always_comb begin
      lane       = addr_q[2:0];
      wordIdx    = addr_q[IdxW+2:3];
      sizeMask   = 8'h01;
      misaligned = 1'b0;
      case (funct3_q[1:0])
         2'b00: begin sizeMask = 8'h01; misaligned = 1'b0; end
         2'b01: begin sizeMask = 8'h03; misaligned = addr_q[0]; end
         2'b10: begin sizeMask = 8'h0F; misaligned = |addr_q[1:0]; end
         default: begin sizeMask = 8'hFF; misaligned = |addr_q[2:0]; end
      endcase
      outOfRange = |addr_q[63:IdxW+3];
      badFunct   = (op_q == OP_BOTH) ||
                   ((op_q == OP_LOAD) && (funct3_q == 3'b111)) ||
                   ((op_q == OP_STORE) && funct3_q[2]);
      accessFault_d = misaligned | outOfRange | badFunct;

      loadWord = memArray[wordIdx] >> {lane, 3'b000};
      case (funct3_q)
         3'b000:  loadData = {{56{loadWord[7]}},  loadWord[7:0]};
         3'b001:  loadData = {{48{loadWord[15]}}, loadWord[15:0]};
         3'b010:  loadData = {{32{loadWord[31]}}, loadWord[31:0]};
         3'b011:  loadData = loadWord;
         3'b100:  loadData = {56'd0, loadWord[7:0]};
         3'b101:  loadData = {48'd0, loadWord[15:0]};
         3'b110:  loadData = {32'd0, loadWord[31:0]};
         default: loadData = 64'd0;
      endcase
      readData_d = ((op_q == OP_LOAD) && !accessFault_d) ? loadData : 64'd0;

      byteEn    = sizeMask << lane;
      storeData = wdata_q << {lane, 3'b000};
      storeEn   = (state_q == ACCESS) && (op_q == OP_STORE) && !accessFault_d;
   end

   // Request FSM with registered handshake outputs; a reset in ACCESS
   // returns to IDLE before the commit edge, so the store never lands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= OP_LOAD;
         addr_q     <= 64'd0;
         wdata_q    <= 64'd0;
         funct3_q   <= 3'd0;
         readData_q <= 64'd0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.MemRead || bus.MemWrite) begin
                  addr_q   <= bus.Address;
                  wdata_q  <= bus.WriteData;
                  funct3_q <= bus.Funct3;
                  if (bus.MemRead && bus.MemWrite) begin
                     op_q <= OP_BOTH;
                  end else if (bus.MemRead) begin
                     op_q <= OP_LOAD;
                  end else begin
                     op_q <= OP_STORE;
                  end
                  busy_q  <= 1'b1;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               ready_q    <= 1'b1;
               fault_q    <= accessFault_d;
               readData_q <= readData_d;
               state_q    <= DONE;
            end
            DONE: begin
               ready_q <= 1'b0;
               fault_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Byte-lane store commit; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (storeEn) begin
         for (int b = 0; b < 8; b++) begin
            if (byteEn[b]) begin
               memArray[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
            end
         end
      end
   end

   assign bus.ReadData = readData_q;
   assign bus.Ready    = ready_q;
   assign bus.Busy     = busy_q;
   assign bus.Fault    = fault_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized
// accesses compared against a byte-array reference model.
module tb_data_memory;

   localparam int DEPTH = 256;
   localparam int NBYTES = DEPTH * 8;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   logic [63:0] lastRead;
   logic [7:0]  refBytes [NBYTES];

   data_memory_if bus ();

   data_memory #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends even if the bench itself stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference model: applies the access rules to a flat byte array.
   task automatic modelAccess(input logic rd, input logic wr, input logic [63:0] addr,
                              input logic [63:0] data, input logic [2:0] f3,
                              output logic expFault, output logic [63:0] expData);
      int size;
      logic [63:0] val;
      size = 1 << f3[1:0];
      expFault = 1'b0;
      if (rd && wr) expFault = 1'b1;
      if (rd && !wr && f3 == 3'b111) expFault = 1'b1;
      if (wr && !rd && f3[2]) expFault = 1'b1;
      if ((addr % 64'(size)) != 0) expFault = 1'b1;
      if (addr >= 64'(NBYTES)) expFault = 1'b1;
      expData = 64'd0;
      if (!expFault && rd) begin
         val = 64'd0;
         for (int i = 0; i < size; i++) begin
            val = val | (64'(refBytes[int'(addr) + i]) << (8 * i));
         end
         if (!f3[2] && size < 8 && val[8*size-1]) begin
            val = val | (~64'd0 << (8 * size));
         end
         expData = val;
      end else if (!expFault && wr) begin
         for (int i = 0; i < size; i++) begin
            refBytes[int'(addr) + i] = data[8*i +: 8];
         end
      end
   endtask

   // One complete transaction: request, ACCESS, DONE and back to IDLE.
   task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                input logic [63:0] addr, input logic [63:0] data,
                                input logic [2:0] f3);
      logic expFault;
      logic [63:0] expData;
      modelAccess(rd, wr, addr, data, f3, expFault, expData);
      @(negedge clk);
      bus.MemRead   = rd;
      bus.MemWrite  = wr;
      bus.Address   = addr;
      bus.WriteData = data;
      bus.Funct3    = f3;
      @(posedge clk);
      #1;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      checkOutput({tag, " busyAccess"}, 64'(bus.Busy), 64'd1);
      checkOutput({tag, " readyAccess"}, 64'(bus.Ready), 64'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, " ready"}, 64'(bus.Ready), 64'd1);
      checkOutput({tag, " fault"}, 64'(bus.Fault), 64'(expFault));
      checkOutput({tag, " readData"}, bus.ReadData, expData);
      lastRead = expData;
      @(posedge clk);
      #1;
      checkOutput({tag, " readyIdle"}, 64'(bus.Ready), 64'd0);
      checkOutput({tag, " busyIdle"}, 64'(bus.Busy), 64'd0);
      checkOutput({tag, " faultIdle"}, 64'(bus.Fault), 64'd0);
      checkOutput({tag, " holdData"}, bus.ReadData, lastRead);
   endtask

   initial begin
      logic expFault;
      logic [63:0] expData;
      logic [63:0] addr;
      logic [63:0] data;
      logic [2:0]  f3;
      int r;
      checks   = 0;
      failures = 0;
      lastRead = 64'd0;
      bus.MemRead   = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.Address   = 64'd0;
      bus.WriteData = 64'd0;
      bus.Funct3    = 3'd0;
      for (int i = 0; i < NBYTES; i++) refBytes[i] = 8'h00;

      reset = 1'b1;
      #3;
      checkOutput("reset readData", bus.ReadData, 64'd0);
      checkOutput("reset ready", 64'(bus.Ready), 64'd0);
      checkOutput("reset busy", 64'(bus.Busy), 64'd0);
      checkOutput("reset fault", 64'(bus.Fault), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Doubleword store/load round trip.
      applyStimulus("sd 0x10", 1'b0, 1'b1, 64'h10, 64'h1122334455667788, 3'b011);
      applyStimulus("ld 0x10", 1'b1, 1'b0, 64'h10, 64'd0, 3'b011);
      checkOutput("ld 0x10 const", bus.ReadData, 64'h1122334455667788);

      // Byte store and sign/zero-extended byte loads.
      applyStimulus("sb 0x13", 1'b0, 1'b1, 64'h13, 64'hFF, 3'b000);
      applyStimulus("lb 0x13", 1'b1, 1'b0, 64'h13, 64'd0, 3'b000);
      checkOutput("lb 0x13 const", bus.ReadData, 64'hFFFFFFFFFFFFFFFF);
      applyStimulus("lbu 0x13", 1'b1, 1'b0, 64'h13, 64'd0, 3'b100);
      checkOutput("lbu 0x13 const", bus.ReadData, 64'h00000000000000FF);
      applyStimulus("ld merged", 1'b1, 1'b0, 64'h10, 64'd0, 3'b011);
      checkOutput("ld merged const", bus.ReadData, 64'h11223344FF667788);

      // Fault cases: misalignment, out of range, both requests.
      applyStimulus("lw 0x12", 1'b1, 1'b0, 64'h12, 64'd0, 3'b010);
      applyStimulus("sw 0x12", 1'b0, 1'b1, 64'h12, 64'hDEADBEEF, 3'b010);
      applyStimulus("ld 0x800", 1'b1, 1'b0, 64'h800, 64'd0, 3'b011);
      applyStimulus("both 0x10", 1'b1, 1'b1, 64'h10, 64'h0, 3'b011);
      applyStimulus("ld after faults", 1'b1, 1'b0, 64'h10, 64'd0, 3'b011);
      checkOutput("ld after faults const", bus.ReadData, 64'h11223344FF667788);

      // Idle cycles leave everything unchanged.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         checkOutput("idle busy", 64'(bus.Busy), 64'd0);
         checkOutput("idle data", bus.ReadData, 64'h11223344FF667788);
      end

      // Reset during ACCESS aborts an in-flight store.
      applyStimulus("sd 0x20 prior", 1'b0, 1'b1, 64'h20, 64'h0123456789ABCDEF, 3'b011);
      @(negedge clk);
      bus.MemWrite  = 1'b1;
      bus.Address   = 64'h20;
      bus.WriteData = 64'hAAAAAAAAAAAAAAAA;
      bus.Funct3    = 3'b011;
      @(posedge clk);
      #1;
      bus.MemWrite = 1'b0;
      checkOutput("abort busyAccess", 64'(bus.Busy), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("abort busy", 64'(bus.Busy), 64'd0);
      checkOutput("abort ready", 64'(bus.Ready), 64'd0);
      checkOutput("abort fault", 64'(bus.Fault), 64'd0);
      checkOutput("abort data", bus.ReadData, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      lastRead = 64'd0;
      applyStimulus("ld 0x20", 1'b1, 1'b0, 64'h20, 64'd0, 3'b011);
      checkOutput("ld 0x20 const", bus.ReadData, 64'h0123456789ABCDEF);

      // Continuous load request: one completion every third cycle.
      modelAccess(1'b1, 1'b0, 64'h10, 64'd0, 3'b011, expFault, expData);
      @(negedge clk);
      bus.MemRead = 1'b1;
      bus.Address = 64'h10;
      bus.Funct3  = 3'b011;
      for (int c = 0; c < 9; c++) begin
         @(posedge clk);
         #1;
         checkOutput("hold busy", 64'(bus.Busy), 64'((c % 3) != 2));
         checkOutput("hold ready", 64'(bus.Ready), 64'((c % 3) == 1));
         if ((c % 3) == 1) begin
            checkOutput("hold data", bus.ReadData, expData);
            checkOutput("hold fault", 64'(bus.Fault), 64'd0);
         end
      end
      @(negedge clk);
      bus.MemRead = 1'b0;
      lastRead = expData;

      // Seed the low eight words, then randomized traffic.
      for (int w = 0; w < 8; w++) begin
         applyStimulus("seed", 1'b0, 1'b1, 64'(w * 8), {$urandom, $urandom}, 3'b011);
      end
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 9);
         if (r < 8) addr = 64'($urandom_range(0, 63));
         else if (r == 8) addr = {$urandom, $urandom};
         else addr = 64'h800 + 64'($urandom_range(0, 2047));
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) addr = addr & ~64'((1 << f3[1:0]) - 1);
         data = {$urandom, $urandom};
         r = $urandom_range(0, 19);
         if (r == 0) applyStimulus("rand both", 1'b1, 1'b1, addr, data, f3);
         else if (r < 10) applyStimulus("rand load", 1'b1, 1'b0, addr, data, f3);
         else applyStimulus("rand store", 1'b0, 1'b1, addr, data, f3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
